// File: rtl/avalon_bus_responder_pkg.sv
// Shared constants for the Avalon nibble bus responder: opcodes, FSM states, default depth.
package avalon_bus_responder_pkg;

    localparam int MEM_DEPTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_LDA_LO  = 3'b001,
        OP_LDA_HI  = 3'b010,
        OP_READ    = 3'b011,
        OP_WRITE   = 3'b100,
        OP_RST_PTR = 3'b101,
        OP_RSV6    = 3'b110,
        OP_RSV7    = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        RD_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/avalon_nibble_ram.sv
// Nibble-wide storage: one write port, one registered read port, contents never reset.
module avalon_nibble_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          gclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [3:0]    rdata
);

    logic [3:0] mem [DEPTH];

    always_ff @(posedge gclk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/avalon_bus_responder.sv
// CPU-side nibble bus responder: strobe-edge command decode, address pointer,
// three-state read pipeline and the data-valid / sticky-error flags.
module avalon_bus_responder
    import avalon_bus_responder_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] bus_in,
    output logic [3:0] data_out,
    output logic       EF0,
    output logic       EF1
);

    localparam int         AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [8:0] DEPTH_LIM = 9'(MEM_DEPTH);

    state_e     state, state_nxt;
    logic       prev_stb;
    logic [7:0] addr;
    logic       rd_oob;
    logic [3:0] ram_rdata;

    opcode_e    op;
    logic [3:0] nib;
    logic       stb_edge, exec, drop, in_range, do_rd, do_wr;

    assign op       = opcode_e'(bus_in[7:5]);
    assign nib      = bus_in[3:0];
    assign stb_edge = bus_in[4] & ~prev_stb;
    assign exec     = stb_edge && (state == IDLE);
    assign drop     = stb_edge && (state != IDLE);
    assign in_range = {1'b0, addr} < DEPTH_LIM;
    assign do_rd    = exec && (op == OP_READ);
    assign do_wr    = exec && (op == OP_WRITE);

    // Read is issued on the edge cycle so RAM data is ready while in RD_PEND.
    avalon_nibble_ram #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .gclk  (CLK),
        .we    (do_wr && in_range),
        .waddr (addr[AW-1:0]),
        .wdata (nib),
        .re    (do_rd && in_range),
        .raddr (addr[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        EF0       = 1'b0;
        unique case (state)
            IDLE:    if (do_rd) state_nxt = RD_PEND;
            RD_PEND: state_nxt = RD_DATA;
            RD_DATA: begin
                state_nxt = IDLE;
                EF0       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // prev_stb resets high so a strobe already high at reset release is not an edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_stb <= 1'b1;
            addr     <= 8'h00;
            data_out <= 4'h0;
            EF1      <= 1'b0;
            rd_oob   <= 1'b0;
        end else begin
            prev_stb <= bus_in[4];
            if (exec) begin
                unique case (op)
                    OP_LDA_LO: addr[3:0] <= nib;
                    OP_LDA_HI: addr[7:4] <= nib;
                    OP_READ, OP_WRITE: begin
                        addr <= addr + 8'd1;
                        if (!in_range)
                            EF1 <= 1'b1;
                    end
                    OP_RST_PTR: begin
                        addr <= 8'h00;
                        EF1  <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (drop)
                EF1 <= 1'b1;
            if (do_rd)
                rd_oob <= !in_range;
            if (state == RD_PEND)
                data_out <= rd_oob ? 4'hF : ram_rdata;
        end
    end

endmodule

// File: tb/tb_avalon_bus_responder.sv
// Directed bench: per-cycle vector table for the command flows, hand sequences
// for the dropped-edge and reset-mid-read corners.
module tb_avalon_bus_responder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [3:0] data_out;
    logic       EF0, EF1;

    int checks = 0;
    int errors = 0;

    avalon_bus_responder #(.MEM_DEPTH(32)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus_in   (bus_in),
        .data_out (data_out),
        .EF0      (EF0),
        .EF1      (EF1)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        logic [3:0] d;
        logic       e0;
        logic       e1;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [7:0] b, input logic [3:0] d, input logic e0, input logic e1);
        vec_t v;
        v.b = b; v.d = d; v.e0 = e0; v.e1 = e1;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [3:0] d, input logic e0, input logic e1);
        chk({nm, ".data_out"}, data_out, d);
        chk({nm, ".EF0"}, {3'b0, EF0}, {3'b0, e0});
        chk({nm, ".EF1"}, {3'b0, EF1}, {3'b0, e1});
    endtask

    // Drive one bus word, let it be sampled, then check the post-edge outputs.
    task automatic step(input string nm, input logic [7:0] b, input logic [3:0] d,
                        input logic e0, input logic e1);
        bus_in = b;
        @(posedge CLK);
        #1;
        chk_out(nm, d, e0, e1);
    endtask

    initial begin
        // bus word = {opcode[2:0], strobe, nibble}
        add(8'h00, 4'h0, 0, 0);
        add(8'h33, 4'h0, 0, 0);   // LDA_LO 3
        add(8'h00, 4'h0, 0, 0);
        add(8'h50, 4'h0, 0, 0);   // LDA_HI 0
        add(8'h00, 4'h0, 0, 0);
        add(8'h9A, 4'h0, 0, 0);   // WRITE A -> mem[3]
        add(8'h00, 4'h0, 0, 0);
        add(8'hB0, 4'h0, 0, 0);   // RST_PTR
        add(8'h00, 4'h0, 0, 0);
        add(8'h33, 4'h0, 0, 0);   // LDA_LO 3
        add(8'h00, 4'h0, 0, 0);
        add(8'h70, 4'h0, 0, 0);   // READ edge -> RD_PEND
        add(8'h00, 4'hA, 1, 0);   // RD_DATA: EF0 two cycles after the edge
        add(8'h00, 4'hA, 0, 0);   // back to IDLE, data held
        add(8'h31, 4'hA, 0, 0);   // LDA_LO 1
        add(8'h00, 4'hA, 0, 0);
        add(8'h92, 4'hA, 0, 0);   // WRITE 2 -> mem[1]
        add(8'h00, 4'hA, 0, 0);
        add(8'hB0, 4'hA, 0, 0);   // RST_PTR
        add(8'h00, 4'hA, 0, 0);
        for (int i = 0; i < 5; i++)
            add(8'h97, 4'hA, 0, 0);   // WRITE 7 held high: one write at addr 0
        add(8'h00, 4'hA, 0, 0);
        add(8'h70, 4'hA, 0, 0);   // READ at addr 1 must still see 2
        add(8'h00, 4'h2, 1, 0);
        add(8'h00, 4'h2, 0, 0);
        add(8'h30, 4'h2, 0, 0);   // LDA_LO 0
        add(8'h00, 4'h2, 0, 0);
        add(8'h70, 4'h2, 0, 0);   // READ addr 0
        add(8'h00, 4'h7, 1, 0);
        add(8'h00, 4'h7, 0, 0);
        add(8'h3F, 4'h7, 0, 0);   // LDA_LO F
        add(8'h00, 4'h7, 0, 0);
        add(8'h51, 4'h7, 0, 0);   // LDA_HI 1 -> addr 0x1F (last legal)
        add(8'h00, 4'h7, 0, 0);
        add(8'h9C, 4'h7, 0, 0);   // WRITE C -> mem[31]
        add(8'h00, 4'h7, 0, 0);
        add(8'h3F, 4'h7, 0, 0);   // LDA_LO F
        add(8'h00, 4'h7, 0, 0);
        add(8'h5F, 4'h7, 0, 0);   // LDA_HI F -> addr 0xFF
        add(8'h00, 4'h7, 0, 0);
        add(8'h95, 4'h7, 0, 1);   // out-of-range WRITE: EF1, dropped, wrap to 0
        add(8'h00, 4'h7, 0, 1);
        add(8'h70, 4'h7, 0, 1);   // READ addr 0 after wrap
        add(8'h00, 4'h7, 1, 1);
        add(8'h00, 4'h7, 0, 1);
        add(8'h3F, 4'h7, 0, 1);
        add(8'h00, 4'h7, 0, 1);
        add(8'h51, 4'h7, 0, 1);   // addr 0x1F
        add(8'h00, 4'h7, 0, 1);
        add(8'h70, 4'h7, 0, 1);   // mem[31] must be untouched by the dropped write
        add(8'h00, 4'hC, 1, 1);
        add(8'h00, 4'hC, 0, 1);
        add(8'h70, 4'hC, 0, 1);   // addr 0x20: out-of-range READ
        add(8'h00, 4'hF, 1, 1);
        add(8'h00, 4'hF, 0, 1);
        add(8'hB0, 4'hF, 0, 0);   // RST_PTR clears EF1
        add(8'h00, 4'hF, 0, 0);

        // reset state
        bus_in = 8'h00;
        RST    = 1'b0;
        #1;
        chk_out("reset", 4'h0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;

        foreach (vq[i])
            step($sformatf("vec%0d", i), vq[i].b, vq[i].d, vq[i].e0, vq[i].e1);

        // strobe edge one cycle after a READ edge is dropped and sets EF1
        step("drop.rd",    8'h70, 4'hF, 0, 0);
        step("drop.pend",  8'h00, 4'h7, 1, 0);
        step("drop.edge",  8'h93, 4'h7, 0, 1);
        step("drop.idle",  8'h00, 4'h7, 0, 1);
        step("drop.rd2",   8'h70, 4'h7, 0, 1);   // addr 1, mem[1] still 2
        step("drop.pend2", 8'h00, 4'h2, 1, 1);
        step("drop.done",  8'h00, 4'h2, 0, 1);
        step("drop.clr",   8'hB0, 4'h2, 0, 0);
        step("drop.low",   8'h00, 4'h2, 0, 0);

        // reset asserted during RD_PEND aborts the read
        step("rst.rd", 8'h70, 4'h2, 0, 0);
        bus_in = 8'h9F;
        RST    = 1'b0;
        #1;
        chk_out("rst.async", 4'h0, 0, 0);
        @(posedge CLK);
        #1;
        chk_out("rst.hold", 4'h0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;
        step("rst.rel0",  8'h9F, 4'h0, 0, 0);   // strobe high at release: no WRITE
        step("rst.rel1",  8'h9F, 4'h0, 0, 0);
        step("rst.low",   8'h00, 4'h0, 0, 0);
        step("rst.rd2",   8'h70, 4'h0, 0, 0);   // addr 0 after reset, mem[0] still 7
        step("rst.pend2", 8'h00, 4'h7, 1, 0);
        step("rst.done",  8'h00, 4'h7, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
